total_coeff_store: RTL and testbench
====================================

// Module: total_coeff_store
// PURPOSE
//  Neighbour store for CAVLC TotalCoeff, upstream of nC decoding. Captures TotalCoeff of each
//  decoded 4x4 block and serves the left (A) and upper (B) neighbour reads used to form nC.
//  A store: 64-entry current/left-MB register file. B store: line buffer addressed by
//  {mb_num_h[6:0], blk}. Skip-fill FSM writes a constant over all 64 entries for skipped or
//  I_PCM macroblocks.
// PARAMETERS
//  BLK_W    6     width of block index (A depth = 2**BLK_W = 64)
//  MBH_W    7     width of MB column index used in B address
//  TC_W     5     TotalCoeff width (0..16; 31 reserved for nA/nB unavailable)
//  LB_DEPTH 8192  B line-buffer depth = 2**(MBH_W+BLK_W)
// PORTS
//  clk           in   1   clock
//  reset_n       in   1   asynchronous active-low reset
//  tc_wr_en      in   1   one-cycle strobe: TotalCoeff of block tc_wr_blk is final
//  tc_wr_blk     in   6   block index being written (0..49 used)
//  TotalCoeff    in   5   value to store
//  mb_num_h      in   8   current MB column; [6:0] used
//  fill_start    in   1   one-cycle strobe: begin fill of current MB
//  fill_pcm      in   1   sampled with fill_start: 1 -> fill 16 (I_PCM), 0 -> fill 0 (skip)
//  fill_busy     out  1   fill FSM active
//  fill_done     out  1   one-cycle pulse on last fill write
//  TC_rd_n       in   1   active-low read enable for both ports
//  TC_A_rd_addr  in   6   A read address
//  TC_B_rd_addr  in   13  B read address {mb_h[6:0], blk}
//  TC_A_dout     out  5   A read data
//  TC_B_dout     out  5   B read data
// BEHAVIOUR
//  Reset: fill_busy=0, fill_done=0, TC_A_dout=0, TC_B_dout=0, fill counter=0, FSM IDLE.
//   Array contents are not reset (undefined until written or filled).
//  Write: tc_wr_en=1 && !fill_busy -> A[tc_wr_blk] <= TotalCoeff and
//   B[{mb_num_h[6:0], tc_wr_blk}] <= TotalCoeff, same edge. tc_wr_en while fill_busy is dropped.
//  Read: synchronous, 1-cycle latency. TC_rd_n=0 at edge N -> dout valid after edge N.
//   TC_rd_n=1 -> dout holds last value (nC stage samples it a later cycle).
//  Read-during-write, same cycle, same address on a port: dout returns the NEW value.
//   Applies to normal writes and fill writes.
//  Fill FSM:
//   IDLE -> FILL on fill_start. Latches fill value (fill_pcm ? 16 : 0) and mb_num_h[6:0].
//   FILL: counter k = 0..63, one write per cycle to A[k] and B[{mbh_latched, k}].
//   FILL -> IDLE after k=63 (64 cycles busy); fill_done pulses the same cycle as k=63 write.
//   fill_start while busy is ignored.
//   Simultaneous fill_start and tc_wr_en in IDLE: the write is performed, then the fill starts.
//  Counter wraps 63 -> 0 on exit. No overflow states.
//  Reset asserted mid-fill: FSM to IDLE immediately. Partially filled entries keep their
//   values; no done pulse.
//  mb_num_h >= 128: only [6:0] used (aliases, by design for <=2048-px width).
// STRUCTURE
//  Shared package/define.v: TC_W, BLK_W, MBH_W, fill constants TC_PCM=16 and TC_SKIP=0,
//   FSM encodings ST_IDLE/ST_FILL.
//  One sub-module: tc_line_ram (1W1R synchronous RAM, LB_DEPTH x TC_W) for the B store.
//   The A store is an inline register file.
//  Bypass comparators and fill FSM live in the top.
// TESTING
//  1 Write blk=5 TC=7, mb_h=3; next cycle read A=5, B={3,5} -> both dout=7 one cycle later.
//  2 Same-cycle write blk=10 TC=12 and read A=10 -> TC_A_dout=12 after that edge (bypass).
//  3 fill_start, fill_pcm=1, mb_h=2 -> fill_busy 64 cycles, fill_done at cycle 64;
//    reads A=0..63 and B={2,k} all =16.
//  4 tc_wr_en blk=3 TC=9 during fill (skip) -> dropped; A[3]=0 after fill.
//  5 Reset pulse at fill cycle 20 -> fill_busy=0 next edge, douts=0, no fill_done;
//    new fill_start accepted.
//  6 TC_rd_n=1 for 5 cycles after a read of 7 with addresses changing -> dout stays 7.

Source files
------------

// File: rtl/total_coeff_store_pkg.sv
// rtl/total_coeff_store_pkg.sv - shared widths, fill constants and fill FSM encoding
package total_coeff_store_pkg;

    localparam int BLK_W    = 6;
    localparam int MBH_W    = 7;
    localparam int TC_W     = 5;
    localparam int A_DEPTH  = 2 ** BLK_W;
    localparam int LB_AW    = MBH_W + BLK_W;
    localparam int LB_DEPTH = 2 ** LB_AW;

    // Constant written over a whole macroblock by the fill FSM
    localparam logic [TC_W-1:0] TC_PCM  = TC_W'(16);
    localparam logic [TC_W-1:0] TC_SKIP = TC_W'(0);

    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(A_DEPTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/tc_line_ram.sv
// rtl/tc_line_ram.sv - 1W1R synchronous RAM used as the upper-neighbour (B) line buffer
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset (read register only)
//   wr_en/wr_addr/wr_data  write port, one write per cycle
//   rd_en/rd_addr          read port, data registered on the edge where rd_en=1
//   rd_data                registered read data, holds while rd_en=0, read-first on collision
module tc_line_ram
    import total_coeff_store_pkg::*;
#(
    parameter int AW = LB_AW,
    parameter int DW = TC_W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    // Contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/total_coeff_store.sv
// rtl/total_coeff_store.sv - TotalCoeff neighbour store (left A regfile, upper B line buffer, skip/PCM fill)
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   tc_wr_en, tc_wr_blk     write strobe and block index of a final TotalCoeff
//   TotalCoeff              value written to A[blk] and B[{mb_num_h[6:0], blk}]
//   mb_num_h                current MB column, bit 7 aliased away
//   fill_start, fill_pcm    start a 64-entry fill with 16 (pcm=1) or 0 (pcm=0)
//   fill_busy, fill_done    fill in progress / pulse on the last fill write
//   TC_rd_n                 active-low read enable shared by both ports
//   TC_A_rd_addr/TC_A_dout  left-neighbour read, 1-cycle latency, write-first
//   TC_B_rd_addr/TC_B_dout  upper-neighbour read, 1-cycle latency, write-first
module total_coeff_store
    import total_coeff_store_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   tc_wr_en,
    input  logic [BLK_W-1:0]       tc_wr_blk,
    input  logic [TC_W-1:0]        TotalCoeff,
    input  logic [7:0]             mb_num_h,
    input  logic                   fill_start,
    input  logic                   fill_pcm,
    output logic                   fill_busy,
    output logic                   fill_done,
    input  logic                   TC_rd_n,
    input  logic [BLK_W-1:0]       TC_A_rd_addr,
    input  logic [LB_AW-1:0]       TC_B_rd_addr,
    output logic [TC_W-1:0]        TC_A_dout,
    output logic [TC_W-1:0]        TC_B_dout
);

    // Columns >= 128 alias onto 0..127; the top bit is deliberately ignored
    logic unused_mb_num_h_msb;
    assign unused_mb_num_h_msb = mb_num_h[7];

    // ------------------------------------------------------------------
    // Fill FSM
    // ------------------------------------------------------------------
    fill_state_t       state_q, state_d;
    logic [BLK_W-1:0]  fill_k_q;
    logic [TC_W-1:0]   fill_val_q;
    logic [MBH_W-1:0]  fill_mbh_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            fill_k_q   <= '0;
            fill_val_q <= TC_SKIP;
            fill_mbh_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && fill_start) begin
                fill_val_q <= fill_pcm ? TC_PCM : TC_SKIP;
                fill_mbh_q <= mb_num_h[MBH_W-1:0];
            end
            // Natural wrap 63 -> 0 leaves the counter ready for the next fill
            if (state_q == ST_FILL) begin
                fill_k_q <= fill_k_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        fill_busy = 1'b0;
        fill_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                fill_busy = 1'b1;
                if (fill_k_q == LAST_BLK) begin
                    fill_done = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write port mux: fill owns the port while busy, external writes dropped
    // ------------------------------------------------------------------
    logic              wr_en;
    logic [BLK_W-1:0]  wr_blk;
    logic [TC_W-1:0]   wr_data;
    logic [MBH_W-1:0]  wr_mbh;
    logic [LB_AW-1:0]  b_wr_addr;

    always_comb begin
        wr_en   = tc_wr_en;
        wr_blk  = tc_wr_blk;
        wr_data = TotalCoeff;
        wr_mbh  = mb_num_h[MBH_W-1:0];
        if (fill_busy) begin
            wr_en   = 1'b1;
            wr_blk  = fill_k_q;
            wr_data = fill_val_q;
            wr_mbh  = fill_mbh_q;
        end
    end

    assign b_wr_addr = {wr_mbh, wr_blk};

    // ------------------------------------------------------------------
    // A store: register file with write-first read register
    // ------------------------------------------------------------------
    logic [TC_W-1:0] a_mem [A_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            a_mem[wr_blk] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            TC_A_dout <= '0;
        end else if (!TC_rd_n) begin
            TC_A_dout <= (wr_en && wr_blk == TC_A_rd_addr) ? wr_data : a_mem[TC_A_rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // B store: line RAM is read-first, so a same-cycle collision is
    // captured here and substituted on the output
    // ------------------------------------------------------------------
    logic [TC_W-1:0] b_ram_dout;
    logic            b_byp_q;
    logic [TC_W-1:0] b_byp_data_q;

    tc_line_ram #(
        .AW (LB_AW),
        .DW (TC_W)
    ) u_b_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (b_wr_addr),
        .wr_data (wr_data),
        .rd_en   (!TC_rd_n),
        .rd_addr (TC_B_rd_addr),
        .rd_data (b_ram_dout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_byp_q      <= 1'b0;
            b_byp_data_q <= '0;
        end else if (!TC_rd_n) begin
            b_byp_q      <= wr_en && (b_wr_addr == TC_B_rd_addr);
            b_byp_data_q <= wr_data;
        end
    end

    assign TC_B_dout = b_byp_q ? b_byp_data_q : b_ram_dout;

endmodule

// File: tb/tb_total_coeff_store.sv
// tb/tb_total_coeff_store.sv - self-checking bench for total_coeff_store
module tb_total_coeff_store;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tc_wr_en = 1'b0;
    logic [5:0]  tc_wr_blk = '0;
    logic [4:0]  TotalCoeff = '0;
    logic [7:0]  mb_num_h = '0;
    logic        fill_start = 1'b0;
    logic        fill_pcm = 1'b0;
    logic        fill_busy;
    logic        fill_done;
    logic        TC_rd_n = 1'b1;
    logic [5:0]  TC_A_rd_addr = '0;
    logic [12:0] TC_B_rd_addr = '0;
    logic [4:0]  TC_A_dout;
    logic [4:0]  TC_B_dout;

    always #5 clk = ~clk;

    total_coeff_store dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tc_wr_en     (tc_wr_en),
        .tc_wr_blk    (tc_wr_blk),
        .TotalCoeff   (TotalCoeff),
        .mb_num_h     (mb_num_h),
        .fill_start   (fill_start),
        .fill_pcm     (fill_pcm),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .TC_rd_n      (TC_rd_n),
        .TC_A_rd_addr (TC_A_rd_addr),
        .TC_B_rd_addr (TC_B_rd_addr),
        .TC_A_dout    (TC_A_dout),
        .TC_B_dout    (TC_B_dout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain arrays plus a count of fill writes still owed
    int m_a [64];
    bit m_a_ok [64];
    int m_b [8192];
    bit m_b_ok [8192];
    bit m_fill = 0;
    int m_k = 0;
    int m_val = 0;
    int m_mbh = 0;
    int exp_a = 0;
    int exp_b = 0;
    bit exp_a_ok = 1;
    bit exp_b_ok = 1;
    bit exp_busy = 0;
    bit exp_done = 0;

    // Drive one cycle of inputs, advance the model over the coming edge,
    // then return 1 time unit after that edge.
    task automatic cycle(input bit wr, input int blk, input int tc, input int mbh,
                         input bit fs, input bit pcm, input bit rdn, input int ra, input int rb);
        bit was_fill;
        tc_wr_en     = wr;
        tc_wr_blk    = blk[5:0];
        TotalCoeff   = tc[4:0];
        mb_num_h     = mbh[7:0];
        fill_start   = fs;
        fill_pcm     = pcm;
        TC_rd_n      = rdn;
        TC_A_rd_addr = ra[5:0];
        TC_B_rd_addr = rb[12:0];
        was_fill = m_fill;
        if (m_fill) begin
            m_a[m_k] = m_val;
            m_a_ok[m_k] = 1;
            m_b[m_mbh * 64 + m_k] = m_val;
            m_b_ok[m_mbh * 64 + m_k] = 1;
            m_k++;
            if (m_k == 64) begin
                m_fill = 0;
                m_k = 0;
            end
        end else if (wr) begin
            m_a[blk] = tc;
            m_a_ok[blk] = 1;
            m_b[(mbh % 128) * 64 + blk] = tc;
            m_b_ok[(mbh % 128) * 64 + blk] = 1;
        end
        if (!was_fill && fs) begin
            m_fill = 1;
            m_k = 0;
            m_val = pcm ? 16 : 0;
            m_mbh = mbh % 128;
        end
        if (!rdn) begin
            exp_a = m_a[ra];
            exp_a_ok = m_a_ok[ra];
            exp_b = m_b[rb];
            exp_b_ok = m_b_ok[rb];
        end
        exp_busy = m_fill;
        exp_done = m_fill && (m_k == 63);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic model_reset();
        m_fill = 0;
        m_k = 0;
        exp_a = 0;
        exp_b = 0;
        exp_a_ok = 1;
        exp_b_ok = 1;
        exp_busy = 0;
        exp_done = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", fill_busy); end
        n_tests++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", fill_done); end
        n_tests++; if (TC_A_dout !== 5'd0) begin n_fail++; $display("FAIL reset_a_dout: got %0d expected 0", TC_A_dout); end
        n_tests++; if (TC_B_dout !== 5'd0) begin n_fail++; $display("FAIL reset_b_dout: got %0d expected 0", TC_B_dout); end
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_write_read();
        cycle(1, 5, 7, 3, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 3, 0, 0, 0, 5, 3 * 64 + 5);
        n_tests++; if (TC_A_dout !== 5'd7 || exp_a != 7) begin n_fail++; $display("FAIL write_read_a: got %0d expected 7", TC_A_dout); end
        n_tests++; if (TC_B_dout !== 5'd7 || exp_b != 7) begin n_fail++; $display("FAIL write_read_b: got %0d expected 7", TC_B_dout); end
    endtask

    task automatic test_bypass();
        cycle(1, 10, 1, 4, 0, 0, 1, 0, 0);
        cycle(1, 10, 12, 4, 0, 0, 0, 10, 4 * 64 + 10);
        n_tests++; if (TC_A_dout !== 5'd12) begin n_fail++; $display("FAIL bypass_a: got %0d expected 12", TC_A_dout); end
        n_tests++; if (TC_B_dout !== 5'd12) begin n_fail++; $display("FAIL bypass_b: got %0d expected 12", TC_B_dout); end
    endtask

    task automatic test_fill_pcm();
        int busy_cnt = 0;
        int done_cnt = 0;
        cycle(0, 0, 0, 2, 1, 1, 1, 0, 0);
        for (int i = 0; i < 64; i++) begin
            n_tests++; if (fill_busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy_%0d: got %b expected 1", i, fill_busy); end
            n_tests++; if (fill_done !== (i == 63)) begin n_fail++; $display("FAIL fill_done_%0d: got %b expected %b", i, fill_done, i == 63); end
            if (fill_busy === 1'b1) busy_cnt++;
            if (fill_done === 1'b1) done_cnt++;
            idle(1);
        end
        n_tests++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL fill_end_busy: got %b expected 0", fill_busy); end
        n_tests++; if (busy_cnt != 64 || done_cnt != 1) begin n_fail++; $display("FAIL fill_counts: got busy=%0d done=%0d expected 64/1", busy_cnt, done_cnt); end
        for (int k = 0; k < 64; k++) begin
            cycle(0, 0, 0, 0, 0, 0, 0, k, 2 * 64 + k);
            n_tests++; if (TC_A_dout !== 5'd16) begin n_fail++; $display("FAIL fill_a_%0d: got %0d expected 16", k, TC_A_dout); end
            n_tests++; if (TC_B_dout !== 5'd16) begin n_fail++; $display("FAIL fill_b_%0d: got %0d expected 16", k, TC_B_dout); end
        end
    endtask

    task automatic test_fill_drop();
        cycle(0, 0, 0, 5, 1, 0, 1, 0, 0);
        // Read the entry being filled each cycle: old contents are 16, new value 0
        for (int i = 0; i < 64; i++) begin
            cycle(i == 10, 3, 9, 5, 0, 0, 0, i, 5 * 64 + i);
            n_tests++; if (TC_A_dout !== 5'd0) begin n_fail++; $display("FAIL fill_byp_a_%0d: got %0d expected 0", i, TC_A_dout); end
            n_tests++; if (TC_B_dout !== 5'd0) begin n_fail++; $display("FAIL fill_byp_b_%0d: got %0d expected 0", i, TC_B_dout); end
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 3, 5 * 64 + 3);
        n_tests++; if (TC_A_dout !== 5'd0) begin n_fail++; $display("FAIL drop_a3: got %0d expected 0", TC_A_dout); end
        n_tests++; if (TC_B_dout !== 5'd0) begin n_fail++; $display("FAIL drop_b3: got %0d expected 0", TC_B_dout); end
    endtask

    task automatic test_reset_mid_fill();
        int done_cnt = 0;
        cycle(0, 0, 0, 6, 1, 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 6, 0, 0, 0, i, 6 * 64 + i);
        n_tests++; if (TC_A_dout !== 5'd16) begin n_fail++; $display("FAIL pre_reset_a: got %0d expected 16", TC_A_dout); end
        reset_n = 1'b0;
        model_reset();
        #1;
        n_tests++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", fill_busy); end
        n_tests++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", fill_done); end
        n_tests++; if (TC_A_dout !== 5'd0 || TC_B_dout !== 5'd0) begin n_fail++; $display("FAIL midrst_dout: got A=%0d B=%0d expected 0/0", TC_A_dout, TC_B_dout); end
        tc_wr_en = 1'b0; fill_start = 1'b0; TC_rd_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (fill_busy !== 1'b0 || fill_done !== 1'b0) begin n_fail++; $display("FAIL midrst_hold: got busy=%b done=%b expected 0/0", fill_busy, fill_done); end
        reset_n = 1'b1;
        idle(1);
        // Entries 0..19 hold 16 from the aborted fill, 20.. still 0
        cycle(0, 0, 0, 0, 0, 0, 0, 19, 6 * 64 + 19);
        n_tests++; if (TC_A_dout !== 5'd16 || exp_a != 16) begin n_fail++; $display("FAIL partial_a19: got %0d expected 16", TC_A_dout); end
        cycle(0, 0, 0, 0, 0, 0, 0, 20, 6 * 64 + 20);
        n_tests++; if (TC_A_dout !== 5'd0 || exp_a != 0) begin n_fail++; $display("FAIL partial_a20: got %0d expected 0", TC_A_dout); end
        cycle(0, 0, 0, 6, 1, 0, 1, 0, 0);
        n_tests++; if (fill_busy !== 1'b1) begin n_fail++; $display("FAIL refill_busy: got %b expected 1", fill_busy); end
        for (int i = 0; i < 70; i++) begin
            if (fill_done === 1'b1) done_cnt++;
            idle(1);
        end
        n_tests++; if (done_cnt != 1 || fill_busy !== 1'b0) begin n_fail++; $display("FAIL refill_done: got done=%0d busy=%b expected 1/0", done_cnt, fill_busy); end
    endtask

    task automatic test_hold();
        cycle(1, 20, 7, 1, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 20, 64 + 20);
        for (int i = 0; i < 5; i++) begin
            cycle(1, i, 3, 1, 0, 0, 1, $urandom_range(0, 63), $urandom_range(0, 8191));
            n_tests++; if (TC_A_dout !== 5'd7) begin n_fail++; $display("FAIL hold_a_%0d: got %0d expected 7", i, TC_A_dout); end
            n_tests++; if (TC_B_dout !== 5'd7) begin n_fail++; $display("FAIL hold_b_%0d: got %0d expected 7", i, TC_B_dout); end
        end
    endtask

    task automatic test_back_to_back();
        cycle(1, 40, 5, 9, 1, 0, 1, 0, 0);
        cycle(0, 0, 0, 9, 0, 0, 0, 40, 9 * 64 + 40);
        n_tests++; if (TC_A_dout !== 5'd5) begin n_fail++; $display("FAIL b2b_a: got %0d expected 5", TC_A_dout); end
        n_tests++; if (TC_B_dout !== 5'd5) begin n_fail++; $display("FAIL b2b_b: got %0d expected 5", TC_B_dout); end
        n_tests++; if (fill_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", fill_busy); end
        idle(64);
        n_tests++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b expected 0", fill_busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int mbh;
            mbh = $urandom_range(0, 3) + (($urandom % 2) * 128);
            cycle(($urandom % 2) == 1, $urandom_range(0, 63), $urandom_range(0, 16), mbh,
                  ($urandom % 50) == 0, ($urandom % 2) == 1, ($urandom % 3) == 0,
                  $urandom_range(0, 63), $urandom_range(0, 3) * 64 + $urandom_range(0, 63));
            n_tests++; if (fill_busy !== exp_busy || fill_done !== exp_done) begin n_fail++; $display("FAIL rnd_fsm_%0d: got busy=%b done=%b expected %b/%b", i, fill_busy, fill_done, exp_busy, exp_done); end
            if (exp_a_ok) begin
                n_tests++; if (TC_A_dout !== exp_a[4:0]) begin n_fail++; $display("FAIL rnd_a_%0d: got %0d expected %0d", i, TC_A_dout, exp_a); end
            end
            if (exp_b_ok) begin
                n_tests++; if (TC_B_dout !== exp_b[4:0]) begin n_fail++; $display("FAIL rnd_b_%0d: got %0d expected %0d", i, TC_B_dout, exp_b); end
            end
        end
        idle(70);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_fill_pcm();
        test_fill_drop();
        test_reset_mid_fill();
        test_hold();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
